// File: rtl/instr_mem_responder.sv
// Memory-side responder for the fetch-stage instruction port: checks requests, reads a
// 1-cycle synchronous SRAM and returns responses in order through a small FIFO.

package len5_pkg;
  localparam int unsigned XLEN            = 64;
  localparam int unsigned ILEN            = 32;
  localparam int unsigned EXCEPT_TYPE_LEN = 4;

  typedef enum logic [EXCEPT_TYPE_LEN-1:0] {
    E_I_ADDR_MISALIGNED   = 4'h0,
    E_I_ACCESS_FAULT      = 4'h1,
    E_ILLEGAL_INSTRUCTION = 4'h2,
    E_BREAKPOINT          = 4'h3,
    E_LD_ADDR_MISALIGNED  = 4'h4,
    E_LD_ACCESS_FAULT     = 4'h5,
    E_ST_ADDR_MISALIGNED  = 4'h6,
    E_ST_ACCESS_FAULT     = 4'h7,
    E_ENV_CALL_UMODE      = 4'h8,
    E_ENV_CALL_SMODE      = 4'h9,
    E_UNKNOWN             = 4'ha,
    E_ENV_CALL_MMODE      = 4'hb,
    E_I_PAGE_FAULT        = 4'hc,
    E_LD_PAGE_FAULT       = 4'hd,
    E_ST_PAGE_FAULT       = 4'hf
  } except_code_t;
endpackage

module instr_mem_responder
  import len5_pkg::*;
#(
  parameter int unsigned      DEPTH     = 2,
  parameter logic [XLEN-1:0]  BASE_ADDR = 64'h0,
  parameter int unsigned      MEM_WORDS = 1024,
  parameter int unsigned      ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic                we_i,
  input  logic [XLEN-1:0]     addr_i,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [ILEN-1:0]     rdata_o,
  output logic                except_raised_o,
  output except_code_t        except_code_o,
  output logic                sram_en_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  input  logic [ILEN-1:0]     sram_rdata_i
);

  localparam int unsigned     PTR_W     = $clog2(DEPTH);
  localparam int unsigned     CNT_W     = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_WORDS) << 2;

  // Request side
  logic              acc;
  logic              legal;
  logic              misaligned;
  logic              out_of_range;
  logic [XLEN:0]     offset;
  except_code_t      code_d;

  // S1 stage (SRAM read in flight)
  logic              s1_valid;
  logic              s1_exc;
  except_code_t      s1_code;

  // Response FIFO
  logic [ILEN-1:0]   fifo_data [DEPTH];
  logic              fifo_exc  [DEPTH];
  except_code_t      fifo_code [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    occ_next;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes
  always_comb begin
    rvalid_o = (cnt != '0) & !flush_i;
    pop      = rvalid_o & rready_i;
    push     = s1_valid;
    // Occupancy after this cycle's pop, counting the read still in S1
    occ_next = {1'b0, cnt} + (CNT_W + 1)'(s1_valid) - (CNT_W + 1)'(pop);
    gnt_o    = rst_ni & !flush_i & (occ_next < (CNT_W + 1)'(DEPTH));
    acc      = req_i & gnt_o;
  end

  // Request checks; the widened subtraction's borrow flags addresses below the base
  always_comb begin
    offset       = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    misaligned   = addr_i[1:0] != 2'b00;
    out_of_range = offset[XLEN] | (offset[XLEN-1:0] >= MEM_BYTES);
    legal        = !misaligned & !we_i & !out_of_range;
    code_d       = misaligned ? E_I_ADDR_MISALIGNED : E_I_ACCESS_FAULT;
    sram_en_o    = acc & legal;
    sram_addr_o  = ADDR_W'(offset >> 2);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_exc   <= 1'b0;
      s1_code  <= E_I_ADDR_MISALIGNED;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        s1_exc  <= !legal;
        s1_code <= code_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_exc[i]  <= 1'b0;
        fifo_code[i] <= E_I_ADDR_MISALIGNED;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= s1_exc ? '0 : sram_rdata_i;
        fifo_exc[wr_ptr]  <= s1_exc;
        fifo_code[wr_ptr] <= s1_code;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    rdata_o         = fifo_data[rd_ptr];
    except_raised_o = fifo_exc[rd_ptr];
    except_code_o   = fifo_code[rd_ptr];
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: directed scenarios followed by random
// traffic, compared cycle by cycle against a queue-based transaction model.

module tb_instr_mem_responder;
  import len5_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int unsigned MW    = 64;
  localparam int unsigned AW    = 6;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              req;
  logic              gnt;
  logic              we;
  logic [63:0]       addr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic              exc;
  except_code_t      code;
  logic              sram_en;
  logic [AW-1:0]     sram_addr;
  logic [31:0]       sram_rdata;

  instr_mem_responder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .MEM_WORDS (MW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .req_i           (req),
    .gnt_o           (gnt),
    .we_i            (we),
    .addr_i          (addr),
    .rvalid_o        (rvalid),
    .rready_i        (rready),
    .rdata_o         (rdata),
    .except_raised_o (exc),
    .except_code_o   (code),
    .sram_en_o       (sram_en),
    .sram_addr_o     (sram_addr),
    .sram_rdata_i    (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: 1-cycle read latency, garbage on the bus when not reading
  logic [31:0] mem [MW];
  always @(posedge clk) begin
    if (sram_en) sram_rdata <= mem[sram_addr];
    else         sram_rdata <= $urandom;
  end

  typedef struct {
    logic [31:0] data;
    logic        exc;
    logic [3:0]  code;
    int unsigned t;
  } rsp_t;

  rsp_t        q[$];
  int unsigned cyc;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check at negedge against the model, advance the model at posedge
  task automatic cycle();
    rsp_t        r;
    logic        v_exp, g_exp, pop, acc, legal;
    int unsigned idx;
    int          qs;
    @(negedge clk);
    qs    = q.size();
    v_exp = rst_n && !flush && qs > 0 && cyc >= q[0].t + 2;
    pop   = v_exp && rready;
    g_exp = rst_n && !flush && ((qs - (pop ? 1 : 0)) < int'(DEPTH));
    chk("gnt", gnt, g_exp);
    chk("rvalid", rvalid, v_exp);
    if (v_exp) begin
      chk("rdata", rdata, q[0].data);
      chk("except_raised", exc, q[0].exc);
      if (q[0].exc) chk("except_code", code, q[0].code);
    end
    legal  = 1'b0;
    idx    = 0;
    r.data = '0;
    r.exc  = 1'b1;
    r.code = E_I_ACCESS_FAULT;
    r.t    = cyc;
    if (addr[1:0] != 2'b00) begin
      r.code = E_I_ADDR_MISALIGNED;
    end else if (!(we || addr < BASE || addr >= BASE + 64'(4 * MW))) begin
      legal  = 1'b1;
      idx    = int'((addr - BASE) / 4);
      r.exc  = 1'b0;
      r.data = mem[idx];
    end
    acc = req && g_exp;
    chk("sram_en", sram_en, acc && legal);
    if (acc && legal) chk("sram_addr", sram_addr, idx);
    @(posedge clk);
    cyc++;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(r);
    end
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // A push into a full FIFO must never happen
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(dut.s1_valid && !flush && dut.cnt == DEPTH && !(rvalid && rready))) else begin
        miscompares++;
        $error("FAIL push_full observed=cnt %0d expected=below %0d", dut.cnt, DEPTH);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    for (int i = 0; i < int'(MW); i++) mem[i] = $urandom;
    mem[2] = 32'h00A00093;
    rst_n  = 1'b0;
    flush  = 1'b0;
    req    = 1'b1;
    we     = 1'b0;
    addr   = BASE;
    rready = 1'b1;

    // Reset: no grant even with a request pending, all outputs cleared
    cycle();
    cycle();
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_except", exc, 1'b0);
    rst_n = 1'b1;
    req   = 1'b0;
    cycle();

    // Single legal read at BASE+8
    req  = 1'b1;
    addr = BASE + 64'd8;
    cycle();
    req = 1'b0;
    cycle();
    chk("lat_rdata_t2", rdata, 32'h00A00093);
    cycle();
    idle(2);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) begin
      req  = 1'b1;
      addr = BASE + 64'(4 * i);
      cycle();
    end
    idle(4);

    // Back-pressure: two grants then stall; release restores gnt in the same cycle
    rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req  = 1'b1;
      addr = BASE + 64'(4 * (10 + i));
      cycle();
    end
    rready = 1'b1;
    cycle();
    idle(4);

    // Exceptions and range boundaries
    req = 1'b1;
    addr = BASE + 64'd2;                   cycle();
    addr = BASE + 64'(4 * MW);             cycle();
    addr = BASE + 64'(4 * MW - 4);         cycle();
    addr = BASE - 64'd4;                   cycle();
    addr = BASE + 64'd16; we = 1'b1;       cycle();
    we = 1'b0;
    idle(4);

    // Flush with two responses pending
    rready = 1'b0;
    req = 1'b1;
    addr = BASE + 64'd20; cycle();
    addr = BASE + 64'd24; cycle();
    idle(2);
    req = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    rready = 1'b1;
    addr = BASE + 64'd28;
    cycle();
    idle(4);

    // Asynchronous reset mid-stream
    rready = 1'b0;
    req = 1'b1;
    addr = BASE + 64'd32; cycle();
    addr = BASE + 64'd36; cycle();
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", rvalid, 1'b0);
    chk("async_rst_gnt", gnt, 1'b0);
    cycle();
    rst_n = 1'b1;
    rready = 1'b1;
    req = 1'b1;
    addr = BASE + 64'd40;
    cycle();
    idle(4);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      req    = ($urandom_range(0, 9) < 7);
      rready = ($urandom_range(0, 9) < 6);
      flush  = ($urandom_range(0, 29) == 0);
      we     = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0: addr = BASE + 64'(4 * $urandom_range(0, MW - 1)) + 64'($urandom_range(1, 3));
        1: addr = BASE - 64'(4 * $urandom_range(1, 8));
        2: addr = BASE + 64'(4 * MW) + 64'(4 * $urandom_range(0, 8));
        3: addr = {$urandom, $urandom};
        default: addr = BASE + 64'(4 * $urandom_range(0, MW - 1));
      endcase
      cycle();
    end
    flush  = 1'b0;
    we     = 1'b0;
    rready = 1'b1;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
